program_counter_unit: RTL and testbench
=======================================

Name: program_counter_unit

Overview:
- Parametrised successor to the single-register PC for the RV32I core.
- Holds the architectural fetch PC and generates the sequential next PC internally.
- Arbitrates stall, branch/jump redirect, trap entry and trap return, and checks target alignment.
- Adds a post-reset boot hold so instruction memory settles before the first fetch. Sits between the branch/control unit and instruction memory.

Parameters:
- XLEN, 32, PC and target width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry or misaligned redirect.
- BOOT_DELAY, 2, cycles after reset release before fetch_valid asserts (0 allowed).
- INCR, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC this cycle.
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  XLEN  branch/jump destination.
- trap_req  in  1  exception/ecall entry request.
- trap_return  in  1  return to saved EPC.
- current_pc  out  XLEN  registered fetch PC.
- pc_plus_incr  out  XLEN  current_pc + INCR, combinational, used for link address.
- fetch_valid  out  1  current_pc is valid for fetch.
- epc  out  XLEN  saved exception PC.
- misaligned_fault  out  1  one-cycle pulse on a misaligned redirect.

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - current_pc=RESET_VECTOR, epc=0, fetch_valid=0, misaligned_fault=0.
  - state=BOOT, boot counter=0.
- BOOT state:
  - All control inputs ignored; PC held at RESET_VECTOR.
  - Counter increments each clk.
  - When counter==BOOT_DELAY-1, go to RUN next edge.
  - BOOT_DELAY=0: go straight to RUN on the first edge after release.
- RUN state: fetch_valid=1. Each rising edge, the first matching rule in this priority order applies:
  1. trap_req: epc<=current_pc; current_pc<=TRAP_VECTOR.
  2. trap_return: current_pc<=epc.
  3. redirect_valid with a misaligned target: misaligned_fault<=1 for exactly one cycle; epc<=current_pc; current_pc<=TRAP_VECTOR.
  4. redirect_valid with an aligned target: current_pc<=redirect_target.
  5. stall: current_pc held.
  6. Otherwise: current_pc<=current_pc+INCR.
- Stall does not block trap or redirect; these override it, because the control unit has already resolved them.
- Arithmetic is modulo 2^XLEN; current_pc at 32'hFFFF_FFFC with INCR=4 wraps to 0 with no flag.
- Latency: every input acts on the next rising edge. current_pc is always a flop output. pc_plus_incr is combinational from current_pc.
- misaligned_fault deasserts the following cycle unless a new misaligned redirect occurs.
- Reset mid-operation returns to BOOT immediately; any pending redirect or trap is discarded.
- trap_req and trap_return together: trap_req wins and epc is overwritten.

Optional Feature:
- Macro: PC_COMPRESSED_ALIGN_EN.
- Defined: 2-byte alignment; a target is misaligned only if redirect_target[0]=1.
- Undefined: 4-byte alignment; a target is misaligned if redirect_target[1:0]!=0.
- INCR is unaffected in both cases.

Decomposition:
- Package pc_pkg:
  - pc_state_e enum (BOOT, RUN).
  - Default RESET_VECTOR and TRAP_VECTOR localparams.
  - Function is_misaligned(target).
- Sub-module pc_boot_timer: BOOT_DELAY counter emitting boot_done. The remaining logic stays flat in program_counter_unit.

Test Plan:
- Reset release, BOOT_DELAY=2 -> fetch_valid=0 for 2 edges with current_pc=0, then 1. Sequence continues 0,4,8,...
- In RUN at pc=8, stall for 3 cycles -> current_pc stays 8 for 3 cycles, then 12.
- At pc=12: redirect_valid=1, target=32'h40 and stall=1 -> next pc=32'h40 and pc_plus_incr=32'h44.
- At pc=32'h44, redirect target=32'h52:
  - Macro undefined -> misaligned_fault pulses once, epc=32'h44, pc=32'h100.
  - Macro defined -> pc=32'h52 and no fault.
- At pc=32'h20, trap_req -> pc=32'h100 and epc=32'h20. Two sequential cycles, then trap_return -> pc=32'h20.
- Force pc=32'hFFFF_FFFC via redirect -> next pc=0. Assert reset mid-run -> current_pc=0 and fetch_valid=0 immediately, asynchronous to clk.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter unit.
// Alignment rule depends on PC_COMPRESSED_ALIGN_EN: when defined, targets only
// need 2-byte alignment; otherwise 4-byte alignment is required.
package pc_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    // Flags a redirect target whose low bits break instruction alignment.
    function automatic logic is_misaligned(input logic [1:0] target_lsbs);
`ifdef PC_COMPRESSED_ALIGN_EN
        return target_lsbs[0];
`else
        return |target_lsbs;
`endif
    endfunction

endpackage

// File: rtl/pc_boot_timer.sv
// Post-reset boot hold counter. boot_done is high during the last BOOT cycle,
// so the owner moves to RUN on the following edge. BOOT_DELAY=0 means
// boot_done is permanently high and the hold lasts a single edge.
module pc_boot_timer #(
    parameter int BOOT_DELAY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    output logic boot_done
);

    localparam int CNT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam int LAST  = (BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0;

    logic [CNT_W-1:0] count;

    assign boot_done = (BOOT_DELAY == 0) || (count == CNT_W'(LAST));

    // Count cycles spent in BOOT, saturating at the terminal value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (count_en && !boot_done) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/program_counter_unit.sv
// Fetch program counter for the RV32I core: boot hold after reset, then
// prioritised trap entry / trap return / redirect / stall / sequential advance.
// Optional macro PC_COMPRESSED_ALIGN_EN relaxes redirect alignment to 2 bytes.
module program_counter_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
    parameter int              BOOT_DELAY   = 2,
    parameter int              INCR         = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_req,
    input  logic            trap_return,
    output logic [XLEN-1:0] current_pc,
    output logic [XLEN-1:0] pc_plus_incr,
    output logic            fetch_valid,
    output logic [XLEN-1:0] epc,
    output logic            misaligned_fault
);

    pc_state_e state;
    logic      boot_done;
    logic      target_bad;

    pc_boot_timer #(
        .BOOT_DELAY (BOOT_DELAY)
    ) u_boot_timer (
        .clk       (clk),
        .reset     (reset),
        .count_en  (state == BOOT),
        .boot_done (boot_done)
    );

    // Link address and sequential successor; wraps modulo 2^XLEN.
    assign pc_plus_incr = current_pc + XLEN'(INCR);
    assign target_bad   = is_misaligned(redirect_target[1:0]);

    // Boot/run sequencing and next-PC arbitration; trap beats return beats redirect beats stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= BOOT;
            current_pc       <= RESET_VECTOR;
            epc              <= '0;
            fetch_valid      <= 1'b0;
            misaligned_fault <= 1'b0;
        end else begin
            misaligned_fault <= 1'b0;
            case (state)
                BOOT: begin
                    if (boot_done) begin
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (trap_req) begin
                        epc        <= current_pc;
                        current_pc <= TRAP_VECTOR;
                    end else if (trap_return) begin
                        current_pc <= epc;
                    end else if (redirect_valid && target_bad) begin
                        misaligned_fault <= 1'b1;
                        epc              <= current_pc;
                        current_pc       <= TRAP_VECTOR;
                    end else if (redirect_valid) begin
                        current_pc <= redirect_target;
                    end else if (!stall) begin
                        current_pc <= pc_plus_incr;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_counter_unit.sv
// Scoreboard bench for program_counter_unit with default parameters.
module tb_program_counter_unit;

`ifdef PC_COMPRESSED_ALIGN_EN
    localparam bit C = 1'b1;
`else
    localparam bit C = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_req;
    logic        trap_return;
    logic [31:0] current_pc;
    logic [31:0] pc_plus_incr;
    logic        fetch_valid;
    logic [31:0] epc;
    logic        misaligned_fault;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        fv;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    program_counter_unit dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .trap_req         (trap_req),
        .trap_return      (trap_return),
        .current_pc       (current_pc),
        .pc_plus_incr     (pc_plus_incr),
        .fetch_valid      (fetch_valid),
        .epc              (epc),
        .misaligned_fault (misaligned_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s step %0d: got %h expected %h", name, id, act, req);
    endtask

    // Monitor: on each falling edge, compare DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("current_pc", e.id, current_pc, e.pc);
                check("pc_plus_incr", e.id, pc_plus_incr, e.pc + 32'd4);
                check("epc", e.id, epc, e.epc);
                check("fetch_valid", e.id, {31'd0, fetch_valid}, {31'd0, e.fv});
                check("misaligned_fault", e.id, {31'd0, misaligned_fault}, {31'd0, e.fault});
            end
        end
    end

    int step_id = 0;

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] e_epc, input logic fv, input logic fault);
        exp_t e;
        e.id = step_id; e.pc = pc; e.epc = e_epc; e.fv = fv; e.fault = fault;
        exp_q.push_back(e);
        step_id++;
    endtask

    // Drive one cycle of inputs from a falling edge, record the post-edge expectation.
    task automatic step(input logic st, input logic rv, input logic [31:0] tgt,
                        input logic tr, input logic tret,
                        input logic [31:0] pc, input logic [31:0] e_epc,
                        input logic fv, input logic fault);
        stall = st; redirect_valid = rv; redirect_target = tgt;
        trap_req = tr; trap_return = tret;
        @(posedge clk);
        push_exp(pc, e_epc, fv, fault);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        trap_req = 1'b0; trap_return = 1'b0;
        repeat (2) @(posedge clk);
        push_exp(32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Boot hold: controls ignored for two edges
        step(0, 0, 32'h0,  1, 0, 32'h0, 32'h0, 0, 0);
        step(0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 1, 0);
        step(0, 0, 32'h0,  0, 0, 32'h4, 32'h0, 1, 0);
        step(0, 0, 32'h0,  0, 0, 32'h8, 32'h0, 1, 0);
        // Stall three cycles
        step(1, 0, 32'h0,  0, 0, 32'h8, 32'h0, 1, 0);
        step(1, 0, 32'h0,  0, 0, 32'h8, 32'h0, 1, 0);
        step(1, 0, 32'h0,  0, 0, 32'h8, 32'h0, 1, 0);
        step(0, 0, 32'h0,  0, 0, 32'hC, 32'h0, 1, 0);
        // Redirect overrides stall
        step(1, 1, 32'h40, 0, 0, 32'h40, 32'h0, 1, 0);
        step(0, 0, 32'h0,  0, 0, 32'h44, 32'h0, 1, 0);
        // Half-word target: alignment depends on build option
        step(0, 1, 32'h52, 0, 0, C ? 32'h52 : 32'h100, C ? 32'h0 : 32'h44, 1, !C);
        step(0, 0, 32'h0,  0, 0, C ? 32'h56 : 32'h104, C ? 32'h0 : 32'h44, 1, 0);
        // Odd target faults in every build, back-to-back keeps the pulse high
        step(1, 1, 32'h41, 0, 0, 32'h100, C ? 32'h56 : 32'h104, 1, 1);
        step(0, 1, 32'h41, 0, 0, 32'h100, 32'h100, 1, 1);
        step(0, 1, 32'h20, 0, 0, 32'h20,  32'h100, 1, 0);
        // Trap entry, two sequential cycles, trap return
        step(0, 0, 32'h0,  1, 0, 32'h100, 32'h20, 1, 0);
        step(0, 0, 32'h0,  0, 0, 32'h104, 32'h20, 1, 0);
        step(0, 0, 32'h0,  0, 0, 32'h108, 32'h20, 1, 0);
        step(0, 0, 32'h0,  0, 1, 32'h20,  32'h20, 1, 0);
        step(0, 0, 32'h0,  0, 0, 32'h24,  32'h20, 1, 0);
        // trap_req beats trap_return; trap_return beats redirect
        step(0, 0, 32'h0,  1, 1, 32'h100, 32'h24, 1, 0);
        step(0, 1, 32'h80, 0, 1, 32'h24,  32'h24, 1, 0);
        // Wrap-around at the top of the address space
        step(0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h24, 1, 0);
        step(0, 0, 32'h0,  0, 0, 32'h0, 32'h24, 1, 0);
        step(0, 0, 32'h0,  0, 0, 32'h4, 32'h24, 1, 0);

        // Asynchronous reset mid-cycle with a trap pending
        trap_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
        @(posedge clk);
        #2 reset = 1'b0;
        push_exp(32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        push_exp(32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        trap_req = 1'b0; redirect_valid = 1'b0;
        reset = 1'b1;
        step(0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 0, 0, 32'h4, 32'h0, 1, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
